// File: rtl/ssd_scan_driver.sv
// Seven-segment scan driver for the BaSys four-digit display.
//
// Scans a 16-bit value as four hex digits, one digit slot at a time, with an
// all-off guard gap at the start of every slot to prevent ghosting. Display
// writes are double-buffered and only reach the scanned value at a frame
// boundary, so a frame never mixes old and new digits.
//
// Ports:
//   CLK_50MHZ_IN  system clock, rising edge
//   rst_n         asynchronous active-low reset
//   disp_we       write strobe for disp_val
//   disp_val      display value, [3:0] = digit 0 (rightmost), [15:12] = digit 3
//   blank_in      per-digit force-blank, active high, live
//   lz_en         leading-zero suppression enable, live
//   ssd_seg_out   segments, active low, bit0 = a .. bit6 = g
//   ssd_sel_out   digit select, active low, bit n = digit n
//   frame_tick    one-cycle pulse with the first output of each new frame
module ssd_scan_driver #(
   parameter int unsigned DIGIT_CYCLES = 50000,
   parameter int unsigned GUARD_CYCLES = 500
) (
   input  logic        CLK_50MHZ_IN,
   input  logic        rst_n,
   input  logic        disp_we,
   input  logic [15:0] disp_val,
   input  logic [3:0]  blank_in,
   input  logic        lz_en,
   output logic [6:0]  ssd_seg_out,
   output logic [3:0]  ssd_sel_out,
   output logic        frame_tick
);

   localparam int unsigned CntW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam logic [CntW-1:0] TermCnt  = CntW'(DIGIT_CYCLES - 1);
   localparam logic [CntW-1:0] GuardCnt = CntW'(GUARD_CYCLES);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      idx_q, idx_d;
   logic [15:0]     active_q, active_d;
   logic [15:0]     pend_q, pend_d;
   logic            pend_flag_q, pend_flag_d;
   logic            wrap_q;
   logic [6:0]      seg_q, seg_d;
   logic [3:0]      sel_q, sel_d;
   logic            tick_q;

   logic            at_term;
   logic            boundary;
   logic [3:0]      nibble;
   logic            upper_zero;
   logic            blank;

   function automatic logic [6:0] hex_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Prescaler, digit index and write buffering.
   always_comb begin
      at_term     = (cnt_q == TermCnt);
      boundary    = at_term && (idx_q == 2'd3);
      cnt_d       = at_term ? '0 : cnt_q + 1'b1;
      idx_d       = at_term ? idx_q + 2'd1 : idx_q;
      active_d    = active_q;
      pend_d      = pend_q;
      pend_flag_d = pend_flag_q;
      if (boundary) begin
         // A write landing on the boundary bypasses the pending register.
         pend_flag_d = 1'b0;
         if (disp_we) begin
            active_d = disp_val;
         end else if (pend_flag_q) begin
            active_d = pend_q;
         end
      end else if (disp_we) begin
         pend_d      = disp_val;
         pend_flag_d = 1'b1;
      end
   end

   // Output stage, registered one cycle behind prescaler/index.
   always_comb begin
      nibble = 4'(active_q >> {idx_q, 2'b00});
      case (idx_q)
         2'd1:    upper_zero = (active_q[15:4] == 12'h000);
         2'd2:    upper_zero = (active_q[15:8] == 8'h00);
         2'd3:    upper_zero = (active_q[15:12] == 4'h0);
         default: upper_zero = 1'b0;  // digit 0 always shows
      endcase
      blank = blank_in[idx_q] | (lz_en & upper_zero);
      seg_d = 7'h7F;
      sel_d = 4'hF;
      if (cnt_q >= GuardCnt) begin
         sel_d = ~(4'b0001 << idx_q);
         seg_d = blank ? 7'h7F : hex_seg(nibble);
      end
   end

   always_ff @(posedge CLK_50MHZ_IN or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         idx_q       <= 2'd0;
         active_q    <= 16'h0000;
         pend_q      <= 16'h0000;
         pend_flag_q <= 1'b0;
         wrap_q      <= 1'b0;
         seg_q       <= 7'h7F;
         sel_q       <= 4'hF;
         tick_q      <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         active_q    <= active_d;
         pend_q      <= pend_d;
         pend_flag_q <= pend_flag_d;
         // Delayed twice so the tick lines up with the first output of the frame.
         wrap_q      <= boundary;
         tick_q      <= wrap_q;
         seg_q       <= seg_d;
         sel_q       <= sel_d;
      end
   end

   assign ssd_seg_out = seg_q;
   assign ssd_sel_out = sel_q;
   assign frame_tick  = tick_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver with a small digit period.
module tb_ssd_scan_driver;

   localparam int unsigned DC = 8;
   localparam int unsigned GC = 2;
   localparam int unsigned FrameCyc = 4 * DC;

   localparam logic [6:0] HexTab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        disp_we = 1'b0;
   logic [15:0] disp_val = 16'h0000;
   logic [3:0]  blank_in = 4'h0;
   logic        lz_en = 1'b0;
   logic [6:0]  ssd_seg_out;
   logic [3:0]  ssd_sel_out;
   logic        frame_tick;

   int checks = 0;
   int errors = 0;

   ssd_scan_driver #(
      .DIGIT_CYCLES(DC),
      .GUARD_CYCLES(GC)
   ) dut (
      .CLK_50MHZ_IN(clk),
      .rst_n       (rst_n),
      .disp_we     (disp_we),
      .disp_val    (disp_val),
      .blank_in    (blank_in),
      .lz_en       (lz_en),
      .ssd_seg_out (ssd_seg_out),
      .ssd_sel_out (ssd_sel_out),
      .frame_tick  (frame_tick)
   );

   always #5 clk = ~clk;

   // Reference model: the display is a pure function of the number of clock
   // edges since reset, the value shown this frame, and the live blank inputs.
   int          n;        // edges since reset release
   logic [15:0] latest;   // most recently written value
   logic [15:0] shown;    // value displayed in the current frame
   logic [6:0]  exp_seg;
   logic [3:0]  exp_sel;
   logic        exp_tick;

   function automatic logic [10:0] model_out(input int k, input logic [15:0] v,
                                             input logic [3:0] bl, input logic lz);
      int         pos;
      logic [1:0] dig;
      logic [15:0] hi;
      logic       blank;
      pos = k % DC;
      dig = 2'((k / DC) % 4);
      if (pos < GC) return {7'h7F, 4'hF};
      hi    = v >> {dig, 2'b00};
      blank = bl[dig] || (lz && dig != 2'd0 && hi == 16'h0000);
      return {blank ? 7'h7F : HexTab[hi[3:0]], 4'hF ^ (4'd1 << dig)};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n        <= 0;
         latest   <= 16'h0000;
         shown    <= 16'h0000;
         exp_seg  <= 7'h7F;
         exp_sel  <= 4'hF;
         exp_tick <= 1'b0;
      end else begin
         {exp_seg, exp_sel} <= model_out(n, shown, blank_in, lz_en);
         exp_tick <= (n % FrameCyc == 0) && (n > 0);
         if (disp_we) latest <= disp_val;
         if (n % FrameCyc == FrameCyc - 1) shown <= disp_we ? disp_val : latest;
         n <= n + 1;
      end
   end

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ssd_seg_out, ssd_sel_out, frame_tick} !== {7'h7F, 4'hF, 1'b0}) begin
         errors++;
         $display("FAIL reset: got seg=%b sel=%h tick=%b, want seg=1111111 sel=f tick=0",
                  ssd_seg_out, ssd_sel_out, frame_tick);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_scan();
      int ticks = 0;
      for (int i = 0; i < 2 * FrameCyc; i++) begin
         @(negedge clk);
         if (frame_tick === 1'b1) ticks++;
         checks++;
         if ({ssd_seg_out, ssd_sel_out, frame_tick} !== {exp_seg, exp_sel, exp_tick}) begin
            errors++;
            $display("FAIL scan n=%0d: got seg=%b sel=%h tick=%b, want seg=%b sel=%h tick=%b",
                     n, ssd_seg_out, ssd_sel_out, frame_tick, exp_seg, exp_sel, exp_tick);
         end
      end
      // Edges 0..63 after release: exactly one wrap-aligned tick at edge 32.
      checks++;
      if (ticks != 1) begin
         errors++;
         $display("FAIL scan_tick_count: got %0d ticks, want 1", ticks);
      end
   endtask

   task automatic test_write_midframe();
      for (int i = 0; i < FrameCyc && ((n % FrameCyc) / DC) != 1; i++) @(negedge clk);
      disp_we  = 1'b1;
      disp_val = 16'h1A8F;
      for (int i = 0; i < 2 * FrameCyc; i++) begin
         @(negedge clk);
         disp_we = 1'b0;
         checks++;
         if ({ssd_seg_out, ssd_sel_out, frame_tick} !== {exp_seg, exp_sel, exp_tick}) begin
            errors++;
            $display("FAIL write_mid n=%0d: got seg=%b sel=%h tick=%b, want seg=%b sel=%h tick=%b",
                     n, ssd_seg_out, ssd_sel_out, frame_tick, exp_seg, exp_sel, exp_tick);
         end
      end
   endtask

   task automatic test_last_wins();
      int saw5 = 0;
      int saw7 = 0;
      @(negedge clk);
      disp_we  = 1'b1;
      disp_val = 16'h0005;
      @(negedge clk);
      disp_val = 16'h0007;
      for (int i = 0; i < 2 * FrameCyc; i++) begin
         @(negedge clk);
         disp_we = 1'b0;
         if (ssd_seg_out === 7'b0010010) saw5++;
         if (ssd_seg_out === 7'b1111000) saw7++;
         checks++;
         if ({ssd_seg_out, ssd_sel_out, frame_tick} !== {exp_seg, exp_sel, exp_tick}) begin
            errors++;
            $display("FAIL last_wins n=%0d: got seg=%b sel=%h tick=%b, want seg=%b sel=%h tick=%b",
                     n, ssd_seg_out, ssd_sel_out, frame_tick, exp_seg, exp_sel, exp_tick);
         end
      end
      checks++;
      if (saw5 != 0 || saw7 == 0) begin
         errors++;
         $display("FAIL last_wins_seen: got five=%0d seven=%0d cycles, want five=0 seven>0",
                  saw5, saw7);
      end
   endtask

   task automatic test_lz();
      lz_en = 1'b1;
      for (int v = 0; v < 2; v++) begin
         @(negedge clk);
         disp_we  = 1'b1;
         disp_val = (v == 0) ? 16'h0040 : 16'h0000;
         for (int i = 0; i < 2 * FrameCyc; i++) begin
            @(negedge clk);
            disp_we = 1'b0;
            checks++;
            if ({ssd_seg_out, ssd_sel_out, frame_tick} !== {exp_seg, exp_sel, exp_tick}) begin
               errors++;
               $display("FAIL lz n=%0d: got seg=%b sel=%h tick=%b, want seg=%b sel=%h tick=%b",
                        n, ssd_seg_out, ssd_sel_out, frame_tick, exp_seg, exp_sel, exp_tick);
            end
         end
      end
      lz_en = 1'b0;
   endtask

   task automatic test_blank();
      @(negedge clk);
      blank_in = 4'b0101;
      disp_we  = 1'b1;
      disp_val = 16'h1234;
      for (int i = 0; i < 2 * FrameCyc; i++) begin
         @(negedge clk);
         disp_we = 1'b0;
         checks++;
         if ({ssd_seg_out, ssd_sel_out, frame_tick} !== {exp_seg, exp_sel, exp_tick}) begin
            errors++;
            $display("FAIL blank n=%0d: got seg=%b sel=%h tick=%b, want seg=%b sel=%h tick=%b",
                     n, ssd_seg_out, ssd_sel_out, frame_tick, exp_seg, exp_sel, exp_tick);
         end
      end
      blank_in = 4'h0;
   endtask

   task automatic test_boundary_write();
      for (int i = 0; i < FrameCyc && (n % FrameCyc) != FrameCyc - 1; i++) @(negedge clk);
      disp_we  = 1'b1;
      disp_val = 16'hFFFF;
      for (int i = 0; i < FrameCyc + 8; i++) begin
         @(negedge clk);
         disp_we = 1'b0;
         checks++;
         if ({ssd_seg_out, ssd_sel_out, frame_tick} !== {exp_seg, exp_sel, exp_tick}) begin
            errors++;
            $display("FAIL boundary_we n=%0d: got seg=%b sel=%h tick=%b, want seg=%b sel=%h tick=%b",
                     n, ssd_seg_out, ssd_sel_out, frame_tick, exp_seg, exp_sel, exp_tick);
         end
      end
   endtask

   task automatic test_async_reset();
      // Queue a pending write too, so reset must also discard it.
      @(negedge clk);
      disp_we  = 1'b1;
      disp_val = 16'h9876;
      for (int i = 0; i < FrameCyc && (n % DC) != 4; i++) @(negedge clk);
      disp_we = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ssd_seg_out, ssd_sel_out, frame_tick} !== {7'h7F, 4'hF, 1'b0}) begin
         errors++;
         $display("FAIL async_reset: got seg=%b sel=%h tick=%b, want seg=1111111 sel=f tick=0",
                  ssd_seg_out, ssd_sel_out, frame_tick);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < FrameCyc + 8; i++) begin
         @(negedge clk);
         checks++;
         if ({ssd_seg_out, ssd_sel_out, frame_tick} !== {exp_seg, exp_sel, exp_tick}) begin
            errors++;
            $display("FAIL after_reset n=%0d: got seg=%b sel=%h tick=%b, want seg=%b sel=%h tick=%b",
                     n, ssd_seg_out, ssd_sel_out, frame_tick, exp_seg, exp_sel, exp_tick);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 20 * FrameCyc; i++) begin
         @(negedge clk);
         checks++;
         if ({ssd_seg_out, ssd_sel_out, frame_tick} !== {exp_seg, exp_sel, exp_tick}) begin
            errors++;
            $display("FAIL random n=%0d: got seg=%b sel=%h tick=%b, want seg=%b sel=%h tick=%b",
                     n, ssd_seg_out, ssd_sel_out, frame_tick, exp_seg, exp_sel, exp_tick);
         end
         disp_we  = ($urandom_range(0, 11) == 0);
         // Bias toward small values so leading-zero suppression gets exercised.
         disp_val = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
         if ($urandom_range(0, 47) == 0) blank_in = 4'($urandom);
         if ($urandom_range(0, 47) == 0) lz_en = 1'($urandom);
      end
      disp_we  = 1'b0;
      blank_in = 4'h0;
      lz_en    = 1'b0;
   endtask

   initial begin
      test_reset();
      test_scan();
      test_write_midframe();
      test_last_wins();
      test_lz();
      test_blank();
      test_boundary_write();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
